// File: rtl/mdu_iterative_div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// Latency: none; this file only declares wires.
// Backpressure: the requester watches busy and holds off start until it falls.
interface mdu_iterative_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_iterative_div.sv
// Multi-cycle restoring divider: quotient on lo, remainder on hi, signed or unsigned.
// Latency: WIDTH/BITS_PER_CYCLE + 2 edges from start to done (2 for a zero divisor).
// Backpressure: start is ignored while an operation is in flight; flush aborts it.
module mdu_iterative_div #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic               clock,
  input logic               reset_n,
  mdu_iterative_div_if.slave bus
);
  localparam int             N       = WIDTH / BITS_PER_CYCLE;
  localparam int             CW      = $clog2(N + 1);
  localparam logic [CW-1:0]  N_LOAD  = CW'(N);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_qneg, r_rneg, r_dbz_pend;
  logic             r_commit, r_busy, r_done, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_accept, w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_rem_step, w_quo_step;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_busy_nxt, w_commit_nxt, w_done_nxt, w_dbz_nxt;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  // Operand magnitudes and acceptance; busy also covers the result-staging cycle after FIX
  always_comb begin
    w_a_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    w_b_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    w_a_mag  = w_a_neg ? -bus.dividend : bus.dividend;
    w_b_mag  = w_b_neg ? -bus.divisor : bus.divisor;
    w_b_zero = (bus.divisor == '0);
    w_accept = (r_state == S_IDLE) & ~r_busy & bus.start & ~bus.flush;
  end

  // BITS_PER_CYCLE restoring steps; the quotient register doubles as the dividend shifter
  always_comb begin
    w_rem_step = r_rem;
    w_quo_step = r_quo;
    w_shift    = '0;
    w_diff     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_shift    = {w_rem_step, w_quo_step[WIDTH-1]};
      w_quo_step = {w_quo_step[WIDTH-2:0], 1'b0};
      w_diff     = w_shift - {1'b0, r_dvs};
      if (!w_diff[WIDTH]) begin
        w_rem_step    = w_diff[WIDTH-1:0];
        w_quo_step[0] = 1'b1;
      end else begin
        w_rem_step = w_shift[WIDTH-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: a zero divisor skips CALC entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_b_zero ? S_FIX : S_CALC;
      S_CALC:  if (bus.flush) w_state_nxt = S_IDLE;
               else if (r_cnt == CNT_ONE) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath capture on accept, iterate in CALC; a zero divisor parks the raw dividend in r_quo
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_dbz_pend <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= N_LOAD;
      r_rem      <= '0;
      r_quo      <= w_b_zero ? bus.dividend : w_a_mag;
      r_dvs      <= w_b_mag;
      r_qneg     <= w_a_neg ^ w_b_neg;
      r_rneg     <= w_a_neg;
      r_dbz_pend <= w_b_zero;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CNT_ONE;
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
    end
  end

  // Output decode: FIX arms a commit, the following edge applies sign fixup and pulses done
  always_comb begin
    w_busy_nxt   = (r_state != S_IDLE) & ~bus.flush;
    w_commit_nxt = (r_state == S_FIX) & ~bus.flush;
    w_done_nxt   = r_commit & ~bus.flush;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_dbz_nxt    = r_dbz;
    if (w_done_nxt) begin
      if (r_dbz_pend) begin
        w_lo_nxt  = '1;
        w_hi_nxt  = r_quo;
        w_dbz_nxt = 1'b1;
      end else begin
        w_lo_nxt  = r_qneg ? -r_quo : r_quo;
        w_hi_nxt  = r_rneg ? -r_rem : r_rem;
        w_dbz_nxt = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_commit <= w_commit_nxt;
      r_done   <= w_done_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_dbz    <= w_dbz_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule
